// File: rtl/fifo_chk_pkg.sv
// Shared types, widths and helpers for the FIFO read-side checker.
// State encoding is fixed so HALT keeps its code in every build, even where it is never reached.
package fifo_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fsm_state_e;

    localparam int RD_CNT_W    = 32;
    localparam int ERR_CNT_W   = 16;
    localparam int BURST_CNT_W = 8;
    localparam int DRAIN_CNT_W = 2;

    // Increment that sticks at max_value; narrower counters pass zero-extended values.
    function automatic logic [RD_CNT_W-1:0] sat_inc(
        input logic [RD_CNT_W-1:0] value,
        input logic [RD_CNT_W-1:0] max_value
    );
        logic [RD_CNT_W-1:0] result;
        if (value >= max_value) begin
            result = max_value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_rd_vld_pipe.sv
// Pop-to-valid delay line: vld marks the cycle in which the FIFO read data of a pop is present.
// A synchronous clear drops every in-flight pop.
module fifo_rd_vld_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic pop,
    output logic vld
);

    logic [RD_LAT-1:0] pipe_r;

    // Shift the pop flag in at bit 0; the oldest entry falls off the top.
    always_ff @(posedge clk) begin
        if (clr) begin
            pipe_r <= '0;
        end else begin
            pipe_r <= RD_LAT'({pipe_r, pop});
        end
    end

    assign vld = pipe_r[RD_LAT-1];

endmodule

// File: rtl/fifo_rd_checker.sv
// Burst reader and incrementing-sequence checker for the async FIFO read port (sysclk domain).
// Optional build macro FIFO_CHK_HALT_EN: freeze reading on the first mismatch until reset.
module fifo_rd_checker
    import fifo_chk_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8,
    parameter int RD_LAT    = 1,
    parameter int START_VAL = 0
) (
    input  logic                 sysclk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [DATA_W-1:0]    fifo_dout,
    output logic                 fifo_rd_en,
    output logic                 chk_err,
    output logic [RD_CNT_W-1:0]  rd_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);

    fsm_state_e             state_r;
    fsm_state_e             state_nxt_s;
    logic [BURST_CNT_W-1:0] burst_cnt_r;
    logic [DRAIN_CNT_W-1:0] drain_cnt_r;
    logic [DATA_W-1:0]      exp_r;
    logic [RD_CNT_W-1:0]    rd_cnt_r;
    logic [ERR_CNT_W-1:0]   err_cnt_r;
    logic                   chk_err_r;
    logic                   busy_r;
    logic                   pop_s;
    logic                   busy_nxt_s;
    logic                   vld_s;
    logic                   mismatch_s;
    logic                   burst_last_s;
    logic                   drain_done_s;
    logic                   halt_req_s;

    assign burst_last_s = (burst_cnt_r == BURST_CNT_W'(BURST_LEN - 1));
    assign drain_done_s = (drain_cnt_r == DRAIN_CNT_W'(RD_LAT - 1));
    assign mismatch_s   = (fifo_dout != exp_r);

`ifdef FIFO_CHK_HALT_EN
    assign halt_req_s = vld_s & mismatch_s;
`else
    assign halt_req_s = 1'b0;
`endif

    fifo_rd_vld_pipe #(
        .RD_LAT (RD_LAT)
    ) u_vld_pipe (
        .clk (sysclk),
        .clr (rst),
        .pop (pop_s),
        .vld (vld_s)
    );

    // FSM state register.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: the burst limit is checked before empty so a limit pop always ends the burst.
    always_comb begin
        state_nxt_s = state_r;
        if (halt_req_s) begin
            state_nxt_s = ST_HALT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_nxt_s = ST_READ;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (pop_s && burst_last_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else if (fifo_empty) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_READ;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
`ifdef FIFO_CHK_HALT_EN
                ST_HALT: begin
                    state_nxt_s = ST_HALT;
                end
`endif
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM outputs: pop is gated by empty in the same cycle, busy is decoded ahead for its register.
    always_comb begin
        pop_s      = 1'b0;
        busy_nxt_s = 1'b0;
        case (state_r)
            ST_READ: pop_s = !fifo_empty;
            default: pop_s = 1'b0;
        endcase
        case (state_nxt_s)
            ST_READ, ST_DRAIN: busy_nxt_s = 1'b1;
            default:           busy_nxt_s = 1'b0;
        endcase
    end

    // Burst and drain counters sequencing the READ and DRAIN states.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            burst_cnt_r <= '0;
            drain_cnt_r <= '0;
        end else begin
            if (state_r == ST_IDLE) begin
                burst_cnt_r <= '0;
            end else if (pop_s) begin
                burst_cnt_r <= burst_cnt_r + 8'd1;
            end
            if (state_r == ST_DRAIN) begin
                drain_cnt_r <= drain_cnt_r + 2'd1;
            end else begin
                drain_cnt_r <= '0;
            end
        end
    end

    // Checker datapath: compare on vld, resync the reference to the received word, count.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            exp_r     <= DATA_W'(START_VAL);
            rd_cnt_r  <= '0;
            err_cnt_r <= '0;
            chk_err_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            busy_r    <= busy_nxt_s;
            chk_err_r <= vld_s & mismatch_s;
            if (vld_s) begin
                exp_r    <= fifo_dout + DATA_W'(1'b1);
                rd_cnt_r <= sat_inc(rd_cnt_r, {RD_CNT_W{1'b1}});
                if (mismatch_s) begin
                    err_cnt_r <= ERR_CNT_W'(sat_inc(RD_CNT_W'(err_cnt_r),
                                                    RD_CNT_W'({ERR_CNT_W{1'b1}})));
                end
            end
        end
    end

    assign fifo_rd_en = pop_s;
    assign chk_err    = chk_err_r;
    assign rd_cnt     = rd_cnt_r;
    assign err_cnt    = err_cnt_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Directed bench for fifo_rd_checker: behavioural FIFO models feed a 16-bit DUT and a 4-bit wrap DUT.
// Expected values are hand-computed per scenario.
module tb_fifo_rd_checker;

    logic        sysclk = 1'b0;
    logic        rst;
    logic        fifo_clr;

    logic [15:0] mem [0:255];
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        chk_err;
    logic [31:0] rd_cnt;
    logic [15:0] err_cnt;
    logic        busy;

    logic [3:0]  mem4 [0:15];
    logic [3:0]  wr4_ptr;
    logic [3:0]  rd4_ptr;
    logic [3:0]  fifo_dout4;
    logic        fifo_empty4;
    logic        fifo_rd_en4;
    logic        chk_err4;
    logic [31:0] rd_cnt4;
    logic [15:0] err_cnt4;
    logic        busy4;

    int          checks = 0;
    int          fails  = 0;
    int          err_pulses;
    int          err4_pulses;
    int          underflow;
    int          pop_cnt;
    int          run_len;
    int          bursts[$];
    logic [15:0] dout_d1;
    logic [15:0] err_word;

    always #10 sysclk = ~sysclk;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_empty4 = (wr4_ptr == rd4_ptr);

    fifo_rd_checker #(
        .DATA_W(16), .BURST_LEN(8), .RD_LAT(1), .START_VAL(0)
    ) u_dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .chk_err    (chk_err),
        .rd_cnt     (rd_cnt),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    fifo_rd_checker #(
        .DATA_W(4), .BURST_LEN(8), .RD_LAT(1), .START_VAL(14)
    ) u_dut4 (
        .sysclk     (sysclk),
        .rst        (rst),
        .fifo_empty (fifo_empty4),
        .fifo_dout  (fifo_dout4),
        .fifo_rd_en (fifo_rd_en4),
        .chk_err    (chk_err4),
        .rd_cnt     (rd_cnt4),
        .err_cnt    (err_cnt4),
        .busy       (busy4)
    );

    // FIFO models: one-cycle read latency, flushed by fifo_clr.
    always @(posedge sysclk) begin
        if (fifo_clr) begin
            rd_ptr  <= wr_ptr;
            rd4_ptr <= wr4_ptr;
        end else begin
            if (fifo_rd_en) begin
                fifo_dout <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 8'd1;
            end
            if (fifo_rd_en4) begin
                fifo_dout4 <= mem4[rd4_ptr];
                rd4_ptr    <= rd4_ptr + 4'd1;
            end
        end
    end

    // Monitors: error pulses, failing word, underflow pops, burst lengths.
    always @(posedge sysclk) begin
        dout_d1 <= fifo_dout;
        if (rst) begin
            err_pulses  <= 0;
            err4_pulses <= 0;
            underflow   <= 0;
            pop_cnt     <= 0;
            run_len     <= 0;
            err_word    <= 16'd0;
            bursts.delete();
        end else begin
            if (chk_err) begin
                err_pulses <= err_pulses + 1;
                err_word   <= dout_d1;
            end
            if (chk_err4) err4_pulses <= err4_pulses + 1;
            if ((fifo_rd_en && fifo_empty) || (fifo_rd_en4 && fifo_empty4)) underflow <= underflow + 1;
            if (fifo_rd_en) begin
                run_len <= run_len + 1;
                pop_cnt <= pop_cnt + 1;
            end else if (run_len != 0) begin
                bursts.push_back(run_len);
                run_len <= 0;
            end
        end
    end

    task automatic push(input logic [15:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic push4(input logic [3:0] v);
        mem4[wr4_ptr] = v;
        wr4_ptr = wr4_ptr + 4'd1;
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        rst = 1'b1;
        fifo_clr = 1'b1;
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        fifo_clr = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int quiet = 0;
        for (int i = 0; i < 500 && quiet < 4; i++) begin
            @(negedge sysclk);
            if (!busy && !busy4) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 4) begin
            fails++;
            $display("FAIL %s_timeout: idle cycles %0d, required 4", name, quiet);
        end
    endtask

    task automatic test_reset();
        @(negedge sysclk);
        fifo_clr = 1'b0;
        push(16'd0); push(16'd1); push(16'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge sysclk);
            checks += 5;
            if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL t1_rd_en cyc%0d: got %b expected 0", c, fifo_rd_en); end
            if (rd_cnt !== 32'd0)    begin fails++; $display("FAIL t1_rd_cnt cyc%0d: got %0d expected 0", c, rd_cnt); end
            if (err_cnt !== 16'd0)   begin fails++; $display("FAIL t1_err_cnt cyc%0d: got %0d expected 0", c, err_cnt); end
            if (busy !== 1'b0)       begin fails++; $display("FAIL t1_busy cyc%0d: got %b expected 0", c, busy); end
            if (chk_err !== 1'b0)    begin fails++; $display("FAIL t1_chk_err cyc%0d: got %b expected 0", c, chk_err); end
        end
    endtask

    task automatic test_clean_stream();
        do_reset();
        for (int i = 0; i < 20; i++) push(16'(i));
        wait_quiet("t2");
        checks += 7;
        if (rd_cnt !== 32'd20)  begin fails++; $display("FAIL t2_rd_cnt: got %0d expected 20", rd_cnt); end
        if (err_cnt !== 16'd0)  begin fails++; $display("FAIL t2_err_cnt: got %0d expected 0", err_cnt); end
        if (err_pulses != 0)    begin fails++; $display("FAIL t2_chk_err: got %0d pulses expected 0", err_pulses); end
        if (bursts.size() != 3) begin fails++; $display("FAIL t2_burst_count: got %0d expected 3", bursts.size()); end
        if (bursts.size() > 0 && bursts[0] != 8) begin fails++; $display("FAIL t2_burst0: got %0d expected 8", bursts[0]); end
        if (bursts.size() > 1 && bursts[1] != 8) begin fails++; $display("FAIL t2_burst1: got %0d expected 8", bursts[1]); end
        if (bursts.size() > 2 && bursts[2] != 4) begin fails++; $display("FAIL t2_burst2: got %0d expected 4", bursts[2]); end
    endtask

    task automatic test_drop();
        do_reset();
        for (int i = 0; i < 10; i++) if (i != 5) push(16'(i));
        wait_quiet("t3");
        checks += 3;
        if (err_cnt !== 16'd1)  begin fails++; $display("FAIL t3_err_cnt: got %0d expected 1", err_cnt); end
        if (err_pulses != 1)    begin fails++; $display("FAIL t3_chk_err: got %0d pulses expected 1", err_pulses); end
        if (err_word !== 16'd6) begin fails++; $display("FAIL t3_err_word: got %0d expected 6", err_word); end
`ifdef FIFO_CHK_HALT_EN
        checks += 2;
        if (rd_cnt > 32'd7)       begin fails++; $display("FAIL t3_halt_rd_cnt: got %0d expected <=7", rd_cnt); end
        if (fifo_rd_en !== 1'b0)  begin fails++; $display("FAIL t3_halt_rd_en: got %b expected 0", fifo_rd_en); end
`else
        checks += 1;
        if (rd_cnt !== 32'd9)   begin fails++; $display("FAIL t3_rd_cnt: got %0d expected 9", rd_cnt); end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        push4(4'd14); push4(4'd15); push4(4'd0); push4(4'd1);
        wait_quiet("t4");
        checks += 4;
        if (rd_cnt4 !== 32'd4) begin fails++; $display("FAIL t4_rd_cnt: got %0d expected 4", rd_cnt4); end
        if (err_cnt4 !== 16'd0) begin fails++; $display("FAIL t4_err_cnt: got %0d expected 0", err_cnt4); end
        if (err4_pulses != 0)  begin fails++; $display("FAIL t4_chk_err: got %0d pulses expected 0", err4_pulses); end
        if (rd_cnt !== 32'd0)  begin fails++; $display("FAIL t4_idle_dut: got %0d expected 0", rd_cnt); end
    endtask

    task automatic test_empty_mid_burst();
        do_reset();
        push(16'd0); push(16'd1); push(16'd2);
        repeat (10) @(negedge sysclk);
        checks += 2;
        if (rd_cnt !== 32'd3)    begin fails++; $display("FAIL t5_pause_rd_cnt: got %0d expected 3", rd_cnt); end
        if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL t5_pause_rd_en: got %b expected 0", fifo_rd_en); end
        push(16'd3); push(16'd4); push(16'd5);
        wait_quiet("t5");
        checks += 5;
        if (rd_cnt !== 32'd6)   begin fails++; $display("FAIL t5_rd_cnt: got %0d expected 6", rd_cnt); end
        if (err_cnt !== 16'd0)  begin fails++; $display("FAIL t5_err_cnt: got %0d expected 0", err_cnt); end
        if (underflow != 0)     begin fails++; $display("FAIL t5_underflow: got %0d pops expected 0", underflow); end
        if (err_pulses != 0)    begin fails++; $display("FAIL t5_chk_err: got %0d pulses expected 0", err_pulses); end
        if (bursts.size() != 2) begin fails++; $display("FAIL t5_burst_count: got %0d expected 2", bursts.size()); end
    endtask

    task automatic test_reset_mid_burst();
        bit found = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) push(16'(i));
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge sysclk);
            if (fifo_rd_en && pop_cnt == 3) found = 1'b1;
        end
        checks++;
        if (!found) begin fails++; $display("FAIL t6_fourth_pop: got none expected one within 60 cycles"); end
        rst = 1'b1;
        fifo_clr = 1'b1;
        @(negedge sysclk);
        checks += 4;
        if (rd_cnt !== 32'd0)  begin fails++; $display("FAIL t6_rst_rd_cnt: got %0d expected 0", rd_cnt); end
        if (err_cnt !== 16'd0) begin fails++; $display("FAIL t6_rst_err_cnt: got %0d expected 0", err_cnt); end
        if (busy !== 1'b0)     begin fails++; $display("FAIL t6_rst_busy: got %b expected 0", busy); end
        if (chk_err !== 1'b0)  begin fails++; $display("FAIL t6_rst_chk_err: got %b expected 0", chk_err); end
        rst = 1'b0;
        fifo_clr = 1'b0;
        for (int i = 0; i < 6; i++) push(16'(i));
        wait_quiet("t6");
        checks += 3;
        if (rd_cnt !== 32'd6)  begin fails++; $display("FAIL t6_rd_cnt: got %0d expected 6", rd_cnt); end
        if (err_cnt !== 16'd0) begin fails++; $display("FAIL t6_err_cnt: got %0d expected 0", err_cnt); end
        if (err_pulses != 0)   begin fails++; $display("FAIL t6_chk_err: got %0d pulses expected 0", err_pulses); end
    endtask

    initial begin
        rst      = 1'b1;
        fifo_clr = 1'b1;
        wr_ptr   = 8'd0;
        wr4_ptr  = 4'd0;
        test_reset();
        test_clean_stream();
        test_drop();
        test_wrap();
        test_empty_mid_burst();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
